uart_tx: RTL and testbench
==========================

# uart_tx

Serial transmitter stage of the UART. Accepts bytes over a valid/ready handshake and requests the line through the flow-control block with an active-low request/grant pair. Once granted and enabled, it serialises the byte LSB-first with start and stop framing, timed by a programmable per-bit clock divider. It sits directly upstream of the flow-control stage and drives the UART TX pin.

## Interface
- DIV_W, 16: width of the baud divider.
- tck  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- baud_div_i  in  DIV_W  clock cycles per bit minus 1; sampled at byte accept.
- stop2_i  in  1  1 = two stop bits, 0 = one; sampled at byte accept.
- data_i  in  8  byte to send.
- valid_i  in  1  data_i valid.
- ready_o  out  1  block can accept a byte.
- tx_rts_n_o  out  1  line request to flow control, active-low.
- tx_cts_n_i  in  1  line grant from flow control, active-low.
- tx_enable_i  in  1  TX path enabled by flow control (mode/half-duplex direction).
- tx_o  out  1  serial output, idle high.
- busy_o  out  1  frame in progress (any state other than IDLE).

## Operation
- States: IDLE, REQ, START, DATA, STOP, DONE (PARITY when the parity feature is compiled in).
- IDLE: ready_o=1, tx_rts_n_o=1, tx_o=1. When valid_i & ready_o, latch data_i, baud_div_i and stop2_i, then go to REQ.
- REQ: tx_rts_n_o=0, tx_o=1. Move to START on the first cycle with tx_cts_n_i=0 & tx_enable_i=1. No timeout; waits indefinitely.
- START: tx_o=0 for baud_div+1 cycles.
- DATA: 8 bits, LSB first, each held baud_div+1 cycles. A 3-bit counter tracks the bit index; exit after index 7.
- STOP: tx_o=1 for 1 or 2 bit periods, per the latched stop2.
- DONE: one cycle with tx_rts_n_o=1 and tx_o=1, then IDLE.
- tx_rts_n_o stays 0 from REQ through STOP.
- tx_cts_n_i and tx_enable_i are sampled only in REQ. Deassertion mid-frame does not abort or stretch the frame.
- Bit timer: down-counter loaded with baud_div at each bit start; the bit ends when the counter is 0. baud_div=0 gives 1-cycle bits.
- Input changes on baud_div_i and stop2_i during a frame have no effect.
- Reset mid-frame: immediate return to IDLE and the line goes high. The partial frame is lost.

## Timing
- Reset values: ready_o=1, tx_rts_n_o=1, tx_o=1, busy_o=0. Internal state resets to IDLE and all counters to 0.
- Handshake rules:
  - Transfer occurs on a rising edge with valid_i=1 & ready_o=1.
  - ready_o drops the following cycle.
  - data_i need not stay stable after the transfer.
- Request latency: tx_rts_n_o goes low the cycle after accept.
- Grant latency: the start bit begins the cycle after tx_cts_n_i=0 & tx_enable_i=1 is seen in REQ.
- Frame length from the start-bit edge: (1+8+S)×(baud_div+1) cycles, where S is the number of stop bits. Add (baud_div+1) when parity is present.
- Back-to-back bytes: minimum 2 idle cycles between frames (DONE, then IDLE accept) plus the REQ wait.
- All outputs are registered or decoded from registered state. There is no combinational path from any input to any output.

## Configuration
- UART_TX_PARITY_EN defined:
  - Adds port parity_odd_i (in, 1), sampled at accept.
  - Adds a PARITY state between DATA and STOP, lasting one bit period.
  - The parity bit is the XOR of the 8 data bits, inverted when parity_odd_i=1.
- UART_TX_PARITY_EN undefined: no port, no PARITY state; DATA goes directly to STOP.

## Test plan
- Reset release with valid_i=0: ready_o=1, tx_o=1, tx_rts_n_o=1, busy_o=0, held steady for 100 cycles.
- Byte 0xA5, baud_div=3, stop2=0, tx_cts_n_i tied 0, tx_enable_i=1:
  - tx_rts_n_o goes low 1 cycle after accept.
  - Start bit begins the next cycle.
  - Line pattern is 0,1,0,1,0,0,1,0,1,1 with each bit lasting 4 cycles.
  - ready_o returns to 1 after DONE.
- Grant delay: tx_cts_n_i=1 for 20 cycles after accept:
  - tx_o stays 1 and tx_rts_n_o stays 0 throughout.
  - Start bit begins 1 cycle after tx_cts_n_i falls.
  - Repeat with tx_enable_i=0 while tx_cts_n_i=0: no start bit until tx_enable_i rises.
- Mid-frame tx_cts_n_i=1 and tx_enable_i=0 during DATA: frame completes unchanged.
- stop2=1, baud_div=0, byte 0xFF: frame is 11 cycles, with 2 stop cycles high.
- rst_n asserted during DATA bit 4: tx_o goes to 1 immediately and busy_o to 0. The next byte 0x3C transmits correctly.
- With UART_TX_PARITY_EN, parity_odd_i=0, byte 0x07: parity bit is 1 between data bit 7 and stop.

Source files
------------

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Purpose  : UART serial transmitter. Accepts a byte over valid/ready,
//            requests the line from flow control (active-low RTS/CTS),
//            then sends start, 8 data bits LSB-first, optional parity and
//            1 or 2 stop bits, each bit lasting baud_div+1 clock cycles.
// Options  : UART_TX_PARITY_EN adds parity_odd_i and a PARITY bit period.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx #(
  parameter int DIV_W = 16
) (
  input  logic             tck,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] baud_div_i,
  input  logic             stop2_i,
  input  logic [7:0]       data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             tx_rts_n_o,
  input  logic             tx_cts_n_i,
  input  logic             tx_enable_i,
`ifdef UART_TX_PARITY_EN
  input  logic             parity_odd_i,
`endif
  output logic             tx_o,
  output logic             busy_o
);

  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_REQ    = 3'd1;
  localparam logic [2:0] c_ST_START  = 3'd2;
  localparam logic [2:0] c_ST_DATA   = 3'd3;
  localparam logic [2:0] c_ST_PARITY = 3'd4;
  localparam logic [2:0] c_ST_STOP   = 3'd5;
  localparam logic [2:0] c_ST_DONE   = 3'd6;

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [7:0]       r_data;
  logic [DIV_W-1:0] r_div;
  logic             r_stop2;
  logic [DIV_W-1:0] r_timer;
  logic [2:0]       r_bit_cnt;
  logic             r_stop_cnt;
  logic             w_bit_end;
  logic             w_par_bit;

  // Current bit period expires when the down-counter reaches zero.
  assign w_bit_end = (r_timer == '0);

`ifdef UART_TX_PARITY_EN
  logic r_par_odd;
  // Even parity is the XOR of the data bits; odd parity inverts it.
  assign w_par_bit = (^r_data) ^ r_par_odd;
`else
  assign w_par_bit = 1'b1;
`endif

  // State register; reset drops any partial frame and returns to IDLE.
  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) r_state <= c_ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode; flow-control inputs matter only while in REQ.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:   if (valid_i) w_state_nxt = c_ST_REQ;
      c_ST_REQ:    if (!tx_cts_n_i && tx_enable_i) w_state_nxt = c_ST_START;
      c_ST_START:  if (w_bit_end) w_state_nxt = c_ST_DATA;
      c_ST_DATA: begin
        if (w_bit_end && (r_bit_cnt == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          w_state_nxt = c_ST_PARITY;
`else
          w_state_nxt = c_ST_STOP;
`endif
        end
      end
      c_ST_PARITY: if (w_bit_end) w_state_nxt = c_ST_STOP;
      c_ST_STOP:   if (w_bit_end && (!r_stop2 || r_stop_cnt)) w_state_nxt = c_ST_DONE;
      c_ST_DONE:   w_state_nxt = c_ST_IDLE;
      default:     w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Frame datapath: capture at accept, bit timer and bit/stop counters.
  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      r_data     <= '0;
      r_div      <= '0;
      r_stop2    <= 1'b0;
      r_timer    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par_odd  <= 1'b0;
`endif
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (valid_i) begin
            r_data     <= data_i;
            r_div      <= baud_div_i;
            r_stop2    <= stop2_i;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_par_odd  <= parity_odd_i;
`endif
          end
        end
        // Keep the timer primed so the start bit gets a full period.
        c_ST_REQ: r_timer <= r_div;
        c_ST_START, c_ST_DATA, c_ST_PARITY, c_ST_STOP: begin
          if (w_bit_end) begin
            r_timer <= r_div;
            if (r_state == c_ST_DATA) r_bit_cnt  <= r_bit_cnt + 3'd1;
            if (r_state == c_ST_STOP) r_stop_cnt <= 1'b1;
          end else begin
            r_timer <= r_timer - DIV_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded purely from registered state.
  always_comb begin
    ready_o    = 1'b0;
    tx_rts_n_o = 1'b1;
    tx_o       = 1'b1;
    busy_o     = 1'b1;
    case (r_state)
      c_ST_IDLE: begin
        ready_o = 1'b1;
        busy_o  = 1'b0;
      end
      c_ST_REQ:    tx_rts_n_o = 1'b0;
      c_ST_START: begin
        tx_rts_n_o = 1'b0;
        tx_o       = 1'b0;
      end
      c_ST_DATA: begin
        tx_rts_n_o = 1'b0;
        tx_o       = r_data[r_bit_cnt];
      end
      c_ST_PARITY: begin
        tx_rts_n_o = 1'b0;
        tx_o       = w_par_bit;
      end
      c_ST_STOP:   tx_rts_n_o = 1'b0;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Purpose  : Self-checking bench for uart_tx. Expected line bits are queued
//            when a byte is offered and compared as the frame is captured.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int c_PAR = 1;
`else
  localparam int c_PAR = 0;
`endif

  logic        tck = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] baud_div_i = '0;
  logic        stop2_i = 1'b0;
  logic [7:0]  data_i = '0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic        tx_rts_n_o;
  logic        tx_cts_n_i = 1'b0;
  logic        tx_enable_i = 1'b1;
  logic        parity_odd_i = 1'b0;
  logic        tx_o;
  logic        busy_o;

  int n_cmp = 0;
  int n_err = 0;
  logic exp_q[$];

  uart_tx #(.DIV_W(16)) dut (
    .tck         (tck),
    .rst_n       (rst_n),
    .baud_div_i  (baud_div_i),
    .stop2_i     (stop2_i),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .tx_rts_n_o  (tx_rts_n_o),
    .tx_cts_n_i  (tx_cts_n_i),
    .tx_enable_i (tx_enable_i),
`ifdef UART_TX_PARITY_EN
    .parity_odd_i(parity_odd_i),
`endif
    .tx_o        (tx_o),
    .busy_o      (busy_o)
  );

  always #5 tck = ~tck;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Offer a byte, wait for acceptance, scramble the inputs afterwards and
  // queue the expected line bits. Returns at the negedge after accept.
  task automatic send_byte(input logic [7:0] d, input logic [15:0] div,
                           input logic s2, input logic po);
    int n = 0;
    @(negedge tck);
    data_i = d; baud_div_i = div; stop2_i = s2; parity_odd_i = po; valid_i = 1'b1;
    while (ready_o !== 1'b1 && n < 500) begin @(negedge tck); n++; end
    if (n >= 500) begin
      n_cmp++; n_err++;
      $display("FAIL accept: ready_o never high, got=%b exp=1", ready_o);
    end
    @(negedge tck);
    valid_i = 1'b0;
    data_i = 8'($urandom);
    baud_div_i = 16'($urandom_range(0, 9));
    stop2_i = ~s2;
    parity_odd_i = ~po;
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    if (c_PAR == 1) exp_q.push_back((^d) ^ po);
    exp_q.push_back(1'b1);
    if (s2) exp_q.push_back(1'b1);
  endtask

  // Count negedges until tx_o falls; -1 on timeout.
  task automatic wait_start(output int n);
    n = 0;
    while (tx_o !== 1'b0 && n < 200) begin @(negedge tck); n++; end
    if (n >= 200) n = -1;
  endtask

  // Record each bit at its first cycle and note any change within the bit.
  task automatic capture(input int nbits, input int div,
                         output logic [15:0] bits, output bit stable);
    stable = 1'b1;
    bits = '0;
    for (int b = 0; b < nbits; b++) begin
      bits[b] = tx_o;
      for (int c = 1; c <= div; c++) begin
        @(negedge tck);
        if (tx_o !== bits[b]) stable = 1'b0;
      end
      @(negedge tck);
    end
  endtask

  task automatic test_reset();
    int bad = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge tck);
    rst_n = 1'b1;
    @(negedge tck);
    n_cmp++; if (ready_o !== 1'b1)    begin n_err++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
    n_cmp++; if (tx_o !== 1'b1)       begin n_err++; $display("FAIL reset_tx got=%b exp=1", tx_o); end
    n_cmp++; if (tx_rts_n_o !== 1'b1) begin n_err++; $display("FAIL reset_rts got=%b exp=1", tx_rts_n_o); end
    n_cmp++; if (busy_o !== 1'b0)     begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    for (int i = 0; i < 100; i++) begin
      @(negedge tck);
      if ({ready_o, tx_o, tx_rts_n_o, busy_o} !== 4'b1110) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL reset_idle_hold got=%0d bad cycles exp=0", bad); end
  endtask

  task automatic test_basic();
    int n; logic [15:0] bits; bit st; logic e; int nb = 10 + c_PAR;
    tx_cts_n_i = 1'b0; tx_enable_i = 1'b1;
    send_byte(8'hA5, 16'd3, 1'b0, 1'b0);
    n_cmp++; if (tx_rts_n_o !== 1'b0) begin n_err++; $display("FAIL basic_rts_latency got=%b exp=0", tx_rts_n_o); end
    n_cmp++; if (ready_o !== 1'b0)    begin n_err++; $display("FAIL basic_ready_drop got=%b exp=0", ready_o); end
    n_cmp++; if (tx_o !== 1'b1)       begin n_err++; $display("FAIL basic_req_line got=%b exp=1", tx_o); end
    wait_start(n);
    n_cmp++; if (n !== 1) begin n_err++; $display("FAIL basic_start_latency got=%0d exp=1", n); end
    capture(nb, 3, bits, st);
    n_cmp++; if (st !== 1'b1) begin n_err++; $display("FAIL basic_bit_width got=unstable exp=4-cycle bits"); end
    n_cmp++; if (exp_q.size() !== nb) begin n_err++; $display("FAIL basic_queue got=%0d exp=%0d", exp_q.size(), nb); end
    for (int b = 0; b < nb; b++) begin
      e = exp_q.pop_front();
      n_cmp++; if (bits[b] !== e) begin n_err++; $display("FAIL basic_bit%0d got=%b exp=%b", b, bits[b], e); end
    end
    n_cmp++; if ({tx_rts_n_o, tx_o, ready_o} !== 3'b110) begin n_err++; $display("FAIL basic_done got=%b exp=110", {tx_rts_n_o, tx_o, ready_o}); end
    @(negedge tck);
    n_cmp++; if ({ready_o, busy_o} !== 2'b10) begin n_err++; $display("FAIL basic_idle_return got=%b exp=10", {ready_o, busy_o}); end
  endtask

  task automatic test_grant_delay(input bit use_enable);
    int n; int bad = 0; logic [15:0] bits; bit st; logic e; int nb = 10 + c_PAR;
    if (use_enable) begin tx_cts_n_i = 1'b0; tx_enable_i = 1'b0; end
    else            begin tx_cts_n_i = 1'b1; tx_enable_i = 1'b1; end
    send_byte(8'h5A, 16'd1, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      if (tx_o !== 1'b1 || tx_rts_n_o !== 1'b0) bad++;
      @(negedge tck);
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL grant_hold en=%0d got=%0d bad cycles exp=0", use_enable, bad); end
    tx_cts_n_i = 1'b0; tx_enable_i = 1'b1;
    wait_start(n);
    n_cmp++; if (n !== 1) begin n_err++; $display("FAIL grant_latency en=%0d got=%0d exp=1", use_enable, n); end
    capture(nb, 1, bits, st);
    n_cmp++; if (st !== 1'b1) begin n_err++; $display("FAIL grant_bit_width en=%0d got=unstable exp=2-cycle bits", use_enable); end
    for (int b = 0; b < nb; b++) begin
      e = exp_q.pop_front();
      n_cmp++; if (bits[b] !== e) begin n_err++; $display("FAIL grant_bit%0d en=%0d got=%b exp=%b", b, use_enable, bits[b], e); end
    end
  endtask

  task automatic test_midframe_flow();
    int n; logic [15:0] bits; bit st; logic e; int nb = 10 + c_PAR;
    tx_cts_n_i = 1'b0; tx_enable_i = 1'b1;
    send_byte(8'hC3, 16'd2, 1'b0, 1'b0);
    wait_start(n);
    fork
      begin
        repeat (8) @(negedge tck);
        tx_cts_n_i = 1'b1; tx_enable_i = 1'b0;
      end
    join_none
    capture(nb, 2, bits, st);
    n_cmp++; if (st !== 1'b1) begin n_err++; $display("FAIL midflow_bit_width got=unstable exp=3-cycle bits"); end
    for (int b = 0; b < nb; b++) begin
      e = exp_q.pop_front();
      n_cmp++; if (bits[b] !== e) begin n_err++; $display("FAIL midflow_bit%0d got=%b exp=%b", b, bits[b], e); end
    end
    n_cmp++; if (tx_rts_n_o !== 1'b1) begin n_err++; $display("FAIL midflow_done got=%b exp=1", tx_rts_n_o); end
    tx_cts_n_i = 1'b0; tx_enable_i = 1'b1;
  endtask

  task automatic test_stop2();
    int n; logic [15:0] bits; bit st; logic e; int nb = 11 + c_PAR;
    send_byte(8'hFF, 16'd0, 1'b1, 1'b0);
    wait_start(n);
    n_cmp++; if (n !== 1) begin n_err++; $display("FAIL stop2_start_latency got=%0d exp=1", n); end
    capture(nb, 0, bits, st);
    for (int b = 0; b < nb; b++) begin
      e = exp_q.pop_front();
      n_cmp++; if (bits[b] !== e) begin n_err++; $display("FAIL stop2_bit%0d got=%b exp=%b", b, bits[b], e); end
    end
    // Second stop cycle must end exactly at frame length; DONE follows.
    n_cmp++; if (tx_rts_n_o !== 1'b1) begin n_err++; $display("FAIL stop2_length got rts=%b exp=1 after %0d cycles", tx_rts_n_o, nb); end
  endtask

  task automatic test_reset_midframe();
    int n; logic [15:0] bits; bit st; logic e; int nb = 10 + c_PAR;
    send_byte(8'h96, 16'd3, 1'b0, 1'b0);
    wait_start(n);
    repeat (21) @(negedge tck);
    n_cmp++; if (busy_o !== 1'b1 || tx_o !== 1'b1) begin n_err++; $display("FAIL rstmid_bit4 got=%b%b exp=11", busy_o, tx_o); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (tx_o !== 1'b1)   begin n_err++; $display("FAIL rstmid_tx got=%b exp=1", tx_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got=%b exp=0", busy_o); end
    @(negedge tck);
    rst_n = 1'b1;
    exp_q.delete();
    send_byte(8'h3C, 16'd3, 1'b0, 1'b0);
    wait_start(n);
    n_cmp++; if (n !== 1) begin n_err++; $display("FAIL rstmid_next_latency got=%0d exp=1", n); end
    capture(nb, 3, bits, st);
    n_cmp++; if (st !== 1'b1) begin n_err++; $display("FAIL rstmid_next_width got=unstable exp=4-cycle bits"); end
    for (int b = 0; b < nb; b++) begin
      e = exp_q.pop_front();
      n_cmp++; if (bits[b] !== e) begin n_err++; $display("FAIL rstmid_next_bit%0d got=%b exp=%b", b, bits[b], e); end
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    int n; logic [15:0] bits; bit st; logic e;
    send_byte(8'h07, 16'd1, 1'b0, 1'b0);
    wait_start(n);
    capture(11, 1, bits, st);
    for (int b = 0; b < 11; b++) begin
      e = exp_q.pop_front();
      n_cmp++; if (bits[b] !== e) begin n_err++; $display("FAIL parity_bit%0d got=%b exp=%b", b, bits[b], e); end
    end
    n_cmp++; if (bits[9] !== 1'b1) begin n_err++; $display("FAIL parity_value got=%b exp=1", bits[9]); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_grant_delay(1'b0);
    test_grant_delay(1'b1);
    test_midframe_flow();
    test_stop2();
    test_reset_midframe();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    repeat (5) @(negedge tck);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
